seven_seg_bcd_encoder: RTL
==========================

Name: seven_seg_bcd_encoder

Overview:
Upstream feeder for the 8-digit seven-segment scan multiplexer. It accepts a binary value on a start pulse and converts it to 8 BCD digits with a sequential double-dabble loop (one shift per clock). It then encodes each digit into an 8-bit segment pattern and holds the patterns on seg0..seg7 for the multiplexer. Supports leading-zero blanking, per-digit decimal points and overflow indication.

Parameters:
BIN_W, 27, width of binary input; fixed at 27 (covers 0..99,999,999); conversion runs BIN_W shift cycles.
ACTIVE_LOW, 1, 1 = segment bit 0 means lit (common anode); 0 = patterns inverted (1 means lit).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request conversion; sampled only when idle.
value  input  BIN_W  binary value, captured on accepted start.
blank_lz  input  1  leading-zero blanking enable, captured on accepted start.
dp_mask  input  8  decimal-point enables, bit i drives seg i; captured on accepted start.
busy  output  1  high from accepted start until conversion result is presented.
done  output  1  one-cycle pulse when seg0..seg7 update.
overflow  output  1  high when last captured value > 99,999,999; held until next done.
seg0..seg7  output  8 each  segment patterns; seg0 = least significant digit; bit0=a .. bit6=g, bit7=dp.

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE; busy=0, done=0, overflow=0; every seg = blank (8'hFF if ACTIVE_LOW, else 8'h00); BCD/shift registers cleared.
- FSM: IDLE -> CONVERT -> ENCODE -> IDLE.
- IDLE: start=1 at edge N: capture value, blank_lz, dp_mask; compute overflow flag internally; clear 32-bit BCD accumulator; load shift counter = BIN_W; busy=1 after edge N.
- CONVERT: edges N+1..N+BIN_W (27 edges). Each edge: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left one bit, decrement counter. Exit after counter reaches 0.
- ENCODE: edge N+BIN_W+1 (N+28): write seg0..seg7, update overflow output, done=1 for exactly that cycle, busy=0, return to IDLE. Latency start-to-done = 28 cycles, independent of value.
- start while busy: ignored, no effect on captured inputs. start high in the ENCODE cycle: ignored. start held high continuously: new conversion accepted on each IDLE cycle, i.e. back-to-back every 29 cycles.
- Digit codes, active-high form before polarity: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; dash=40; blank=00. With ACTIVE_LOW=1, the final pattern is the bitwise inverse.
- Leading-zero blanking (blank_lz=1): digits above the most significant nonzero digit are blank. Value 0 shows "0" on seg0 only. blank_lz=0: all 8 digits shown.
- Overflow (value > 99,999,999): all 8 digits show dash regardless of blank_lz; the dp_mask is still applied; overflow output=1.
- Decimal point: bit7 lit when dp_mask[i]=1, including on blanked digits.
- seg0..seg7 change only in the ENCODE cycle or on reset; they are stable otherwise (the multiplexer may sample them at any time).
- Reset mid-conversion: abort immediately to the reset state; no done pulse afterward.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> busy=0, done=0, overflow=0, all seg=8'hFF immediately.
- value=12345678, blank_lz=0, dp_mask=0, start pulse at edge N -> done high exactly after edge N+28; seg0=8'h80 ('8'), seg1=8'hF8 ('7'), seg7=8'hF9 ('1'); overflow=0.
- value=0, blank_lz=1 -> seg0=8'hC0, seg1..seg7=8'hFF. Same with blank_lz=0 -> all seg=8'hC0.
- value=305, blank_lz=1, dp_mask=8'h04 -> seg0=8'h92, seg1=8'hC0, seg2=8'h30 ('3'+dp), seg3..seg7=8'hFF.
- value=100000000 -> overflow=1, all seg=8'hBF. Then value=99999999 -> overflow=0, all seg=8'h90.
- Start conversion A=42; pulse start with value=7 at cycle 10 while busy -> result shows 42, single done pulse. Separately, drop rst_n at cycle 15 of a conversion -> no done pulse, segs blank.

Source files
------------

// File: rtl/seven_seg_bcd_encoder.sv
// seven_seg_bcd_encoder: converts a binary value into 8 BCD digits using a
// sequential double-dabble loop (one shift per clock). It then encodes each
// digit into a seven-segment pattern with decimal point, and holds the result
// on seg0..seg7 for a downstream scan multiplexer.
//
// Handshake: a conversion is accepted when start=1 on a clock edge while the
// block is idle (busy=0). After that edge busy stays high until the edge that
// presents the result. On that edge done pulses for exactly one cycle and the
// segment outputs update. Any start seen while busy is ignored.
module seven_seg_bcd_encoder #(
  parameter int BIN_W      = 27,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  input  logic             blank_lz,
  input  logic [7:0]       dp_mask,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [7:0]       seg0,
  output logic [7:0]       seg1,
  output logic [7:0]       seg2,
  output logic [7:0]       seg3,
  output logic [7:0]       seg4,
  output logic [7:0]       seg5,
  output logic [7:0]       seg6,
  output logic [7:0]       seg7,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_ENCODE  = 2'd2
  } state_t;

  localparam int               CNT_W     = $clog2(BIN_W + 1);
  localparam logic [7:0]       BLANK_PAT = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(99_999_999);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [31:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               blz_q, blz_d;
  logic [7:0]         dp_q, dp_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic [7:0]         seg_q [8];
  logic [7:0]         seg_d [8];
  logic [31:0]        bcd_adj;
  logic [7:0]         enc_seg [8];

  // Active-high segment code (bits g..a) for one BCD digit.
  function automatic logic [6:0] digit_segs(input logic [3:0] d);
    case (d)
      4'd0:    digit_segs = 7'h3F;
      4'd1:    digit_segs = 7'h06;
      4'd2:    digit_segs = 7'h5B;
      4'd3:    digit_segs = 7'h4F;
      4'd4:    digit_segs = 7'h66;
      4'd5:    digit_segs = 7'h6D;
      4'd6:    digit_segs = 7'h7D;
      4'd7:    digit_segs = 7'h07;
      4'd8:    digit_segs = 7'h7F;
      4'd9:    digit_segs = 7'h6F;
      default: digit_segs = 7'h00;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 8; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                    : bcd_q[4*i +: 4];
    end
  end

  // Final patterns: scan from the top digit so leading zeros can be blanked.
  always_comb begin
    logic       any_nz;
    logic [3:0] digit;
    logic [6:0] pat;
    logic [7:0] raw;
    any_nz = 1'b0;
    digit  = '0;
    pat    = '0;
    raw    = '0;
    for (int i = 7; i >= 0; i--) begin
      digit  = bcd_q[4*i +: 4];
      any_nz = any_nz | (digit != 4'd0);
      if (ovf_flag_q)                       pat = 7'h40;
      else if (blz_q && !any_nz && i != 0)  pat = 7'h00;
      else                                  pat = digit_segs(digit);
      raw        = {dp_q[i], pat};
      enc_seg[i] = ACTIVE_LOW ? ~raw : raw;
    end
  end

  // Next-state and datapath control for IDLE -> CONVERT -> ENCODE -> IDLE.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    blz_d      = blz_q;
    dp_d       = dp_q;
    ovf_flag_d = ovf_flag_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    for (int i = 0; i < 8; i++) seg_d[i] = seg_q[i];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d      = value;
          blz_d      = blank_lz;
          dp_d       = dp_mask;
          ovf_flag_d = (value > MAX_VAL);
          bcd_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d = {bcd_adj[30:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_ENCODE;
      end
      S_ENCODE: begin
        for (int i = 0; i < 8; i++) seg_d[i] = enc_seg[i];
        overflow_d = ovf_flag_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; an asynchronous reset aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      blz_q      <= 1'b0;
      dp_q       <= '0;
      ovf_flag_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 8; i++) seg_q[i] <= BLANK_PAT;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      blz_q      <= blz_d;
      dp_q       <= dp_d;
      ovf_flag_q <= ovf_flag_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      for (int i = 0; i < 8; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;
  assign seg0      = seg_q[0];
  assign seg1      = seg_q[1];
  assign seg2      = seg_q[2];
  assign seg3      = seg_q[3];
  assign seg4      = seg_q[4];
  assign seg5      = seg_q[5];
  assign seg6      = seg_q[6];
  assign seg7      = seg_q[7];

endmodule
